load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 39 +++
 rtl/lsu_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Purpose : shared LSU types: operand width, funct3 size codes, FSM states.
// Latency : n/a (types and a pure helper function only).
// Backpr. : n/a.
// Contents: OPERAND_WIDTH, lsu_size_e, lsu_state_e, size_bytes().
package common;

    localparam int OPERAND_WIDTH = 32;

    // funct3-style size/sign codes; D and WU are only legal on a 64-bit bus
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_D  = 3'b011,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101,
        SZ_WU = 3'b110
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        ACCESS2 = 2'd2,
        RESP    = 2'd3
    } lsu_state_e;

    // Access size in bytes; 0 flags a code that is illegal for this bus width.
    function automatic logic [3:0] size_bytes(input logic [2:0] size, input int data_width);
        case (size)
            SZ_B, SZ_BU: size_bytes = 4'd1;
            SZ_H, SZ_HU: size_bytes = 4'd2;
            SZ_W:        size_bytes = 4'd4;
            SZ_D:        size_bytes = (data_width == 64) ? 4'd8 : 4'd0;
            SZ_WU:       size_bytes = (data_width == 64) ? 4'd4 : 4'd0;
            default:     size_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purpose : lane placement for stores / byte enables and load shift + extension.
// Latency : combinational.
// Backpr. : none; pure function of its inputs.
// Ports   : size, offset (byte offset in word), wdata, rdata_lo/rdata_hi (word N, N+1)
//           -> be_lo/be_hi, wdata_lo/wdata_hi (word N, N+1 lanes), load_data.
module lsu_align
    import common::*;
#(
    parameter int DATA_WIDTH = OPERAND_WIDTH,
    localparam int NB = DATA_WIDTH / 8,
    localparam int OW = $clog2(NB)
) (
    input  logic [2:0]            size,
    input  logic [OW-1:0]         offset,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata_lo,
    input  logic [DATA_WIDTH-1:0] rdata_hi,
    output logic [NB-1:0]         be_lo,
    output logic [NB-1:0]         be_hi,
    output logic [DATA_WIDTH-1:0] wdata_lo,
    output logic [DATA_WIDTH-1:0] wdata_hi,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [3:0]              nbytes;
    logic [2*NB-1:0]         mask;
    logic [2*NB-1:0]         be_wide;
    logic [2*DATA_WIDTH-1:0] wd_wide;
    logic [2*DATA_WIDTH-1:0] rd_wide;
    logic [DATA_WIDTH-1:0]   rd;

    assign nbytes = size_bytes(size, DATA_WIDTH);

    // Work on a two-word window: the low half is word N, the high half is
    // word N+1. An aligned access simply never touches the high half.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NB; i++) begin
            mask[i] = (i < int'(nbytes));
        end
        be_wide = mask << offset;
        wd_wide = {{DATA_WIDTH{1'b0}}, wdata} << (8 * offset);
        rd_wide = {rdata_hi, rdata_lo} >> (8 * offset);
        rd      = rd_wide[DATA_WIDTH-1:0];
        case (size)
            SZ_B:    load_data = DATA_WIDTH'($signed(rd[7:0]));
            SZ_H:    load_data = DATA_WIDTH'($signed(rd[15:0]));
            SZ_W:    load_data = DATA_WIDTH'($signed(rd[31:0]));
            SZ_D:    load_data = rd;
            SZ_BU:   load_data = DATA_WIDTH'(rd[7:0]);
            SZ_HU:   load_data = DATA_WIDTH'(rd[15:0]);
            SZ_WU:   load_data = DATA_WIDTH'(rd[31:0]);
            default: load_data = '0;
        endcase
    end

    assign be_lo    = be_wide[NB-1:0];
    assign be_hi    = be_wide[2*NB-1:NB];
    assign wdata_lo = wd_wide[DATA_WIDTH-1:0];
    assign wdata_hi = wd_wide[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/load_store_unit.sv
// Purpose : single-outstanding load/store unit between a core and a word memory.
// Latency : >= 2 cycles from acceptance to resp_valid (ack in first ACCESS cycle).
// Backpr. : req_ready only in IDLE; memory stalls by withholding mem_ack, bounded by TIMEOUT_CYCLES.
// Ports   : clk/rst (sync, active-high); core req_* in, resp_* out; memory mem_* out, mem_ack/mem_rdata in.
// Config  : define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two word accesses;
//           otherwise misaligned accesses return resp_err without touching memory.
module load_store_unit
    import common::*;
#(
    parameter int DATA_WIDTH     = OPERAND_WIDTH,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [2:0]              req_size,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_e            state_q, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            size_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [CW-1:0]         cnt_q;

    logic                  accept, in_second, illegal, misaligned, no_access, timeout;
    logic                  finish, finish_err;
    logic [3:0]            nbytes;
    logic [OW-1:0]         offset;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [NB-1:0]         be_lo, be_hi;
    logic [DATA_WIDTH-1:0] wd_lo, wd_hi, load_data, rd_lo, rd_hi;

    assign accept     = req_valid && req_ready;
    assign in_second  = (state_q == ACCESS2);
    assign offset     = addr_q[OW-1:0];
    assign nbytes     = size_bytes(size_q, DATA_WIDTH);
    assign illegal    = (nbytes == 4'd0);
    assign misaligned = ((4'(offset) & (nbytes - 4'd1)) != 4'd0);
    assign no_access  = illegal || (misaligned && !SPLIT_EN);
    // Ack on the last countable cycle takes priority over the timeout.
    assign timeout    = (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !mem_ack;
    assign word_addr  = {addr_q[ADDR_WIDTH-1:OW], {OW{1'b0}}};

    // In the second half of a split load, word N was parked in rdata1_q.
    assign rd_lo = in_second ? rdata1_q  : mem_rdata;
    assign rd_hi = in_second ? mem_rdata : '0;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size      (size_q),
        .offset    (offset),
        .wdata     (wdata_q),
        .rdata_lo  (rd_lo),
        .rdata_hi  (rd_hi),
        .be_lo     (be_lo),
        .be_hi     (be_hi),
        .wdata_lo  (wd_lo),
        .wdata_hi  (wd_hi),
        .load_data (load_data)
    );

    always_comb begin
        state_nxt  = state_q;
        mem_req    = 1'b0;
        finish     = 1'b0;
        finish_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (no_access) begin
                    state_nxt  = RESP;
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        if (SPLIT_EN && misaligned) begin
                            state_nxt = ACCESS2;
                        end else begin
                            state_nxt = RESP;
                            finish    = 1'b1;
                        end
                    end else if (timeout) begin
                        state_nxt  = RESP;
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACCESS2: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nxt = RESP;
                    finish    = 1'b1;
                end else if (timeout) begin
                    state_nxt  = RESP;
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
`endif
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            rdata1_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                write_q <= req_write;
                wdata_q <= req_wdata;
            end
            if (state_q == ACCESS && mem_req && mem_ack) rdata1_q <= mem_rdata;
            if (finish) begin
                err_q   <= finish_err;
                rdata_q <= (finish_err || write_q) ? '0 : load_data;
            end else if (state_q == RESP) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
            // Counts stalled cycles of the current access; any state change clears it.
            cnt_q <= (mem_req && !mem_ack && state_nxt == state_q) ? cnt_q + 1'b1 : '0;
        end
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_we     = mem_req && write_q;
    assign mem_be     = !mem_req ? '0 : (in_second ? be_hi : be_lo);
    assign mem_addr   = !mem_req ? '0 : word_addr + (in_second ? ADDR_WIDTH'(NB) : '0);
    assign mem_wdata  = !mem_we ? '0 : (in_second ? wd_hi : wd_lo);

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : directed self-checking bench for load_store_unit (32-bit bus, TIMEOUT_CYCLES = 4).
// Latency : n/a.
// Backpr. : n/a.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns #1 after the accepting edge.
    task automatic issue(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 3'b000;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

        // ---- reset state
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        tick();
        rst = 1'b0;
        #1;
        check("idle_req_ready", req_ready, 1);

        // ---- LW 0x10, ack on the fourth ACCESS cycle (same cycle the timeout would hit)
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_mem_req", mem_req, 1);
        check("lw_mem_addr", mem_addr, 32'h10);
        check("lw_mem_be", mem_be, 4'b1111);
        check("lw_mem_we", mem_we, 0);
        check("lw_busy_ready", req_ready, 0);
        repeat (3) tick();
        check("lw_hold_req", mem_req, 1);
        check("lw_hold_addr", mem_addr, 32'h10);
        check("lw_hold_resp", resp_valid, 0);
        ack(32'hDEADBEEF);
        check("lw_resp_valid", resp_valid, 1);
        check("lw_resp_rdata", resp_rdata, 32'hDEADBEEF);
        check("lw_resp_err", resp_err, 0);
        check("lw_resp_mem_req", mem_req, 0);
        tick();
        check("lw_resp_pulse", resp_valid, 0);
        check("lw_back_ready", req_ready, 1);

        // ---- LB / LBU at 0x13 (byte lane 3), minimum latency path
        issue(1'b0, 3'b000, 32'h13, 32'h0);
        check("lb_mem_be", mem_be, 4'b1000);
        check("lb_mem_addr", mem_addr, 32'h10);
        ack(32'h80112233);
        check("lb_resp_valid", resp_valid, 1);
        check("lb_sext", resp_rdata, 32'hFFFFFF80);
        tick();
        issue(1'b0, 3'b100, 32'h13, 32'h0);
        ack(32'h80112233);
        check("lbu_zext", resp_rdata, 32'h00000080);
        tick();

        // ---- LH / LHU at 0x12 (upper half)
        issue(1'b0, 3'b001, 32'h12, 32'h0);
        check("lh_mem_be", mem_be, 4'b1100);
        ack(32'hBEEF1234);
        check("lh_sext", resp_rdata, 32'hFFFFBEEF);
        tick();
        issue(1'b0, 3'b101, 32'h12, 32'h0);
        ack(32'hBEEF1234);
        check("lhu_zext", resp_rdata, 32'h0000BEEF);
        tick();

        // ---- SH 0x22, SB 0x05
        issue(1'b1, 3'b001, 32'h22, 32'h0000ABCD);
        check("sh_mem_addr", mem_addr, 32'h20);
        check("sh_mem_be", mem_be, 4'b1100);
        check("sh_mem_wdata", mem_wdata, 32'hABCD0000);
        check("sh_mem_we", mem_we, 1);
        ack(32'h12345678);
        check("sh_resp_rdata", resp_rdata, 0);
        check("sh_resp_err", resp_err, 0);
        tick();
        issue(1'b1, 3'b000, 32'h05, 32'h000000A5);
        check("sb_mem_addr", mem_addr, 32'h04);
        check("sb_mem_be", mem_be, 4'b0010);
        check("sb_mem_wdata", mem_wdata, 32'h0000A500);
        ack(32'h0);
        check("sb_resp_valid", resp_valid, 1);
        tick();

        // ---- misaligned LW at 0x01
`ifdef LSU_MISALIGN_SPLIT_EN
        issue(1'b0, 3'b010, 32'h01, 32'h0);
        check("mis_a1_req", mem_req, 1);
        check("mis_a1_addr", mem_addr, 32'h00);
        check("mis_a1_be", mem_be, 4'b1110);
        ack(32'h44332211);
        check("mis_a2_req", mem_req, 1);
        check("mis_a2_addr", mem_addr, 32'h04);
        check("mis_a2_be", mem_be, 4'b0001);
        check("mis_a2_noresp", resp_valid, 0);
        ack(32'h88776655);
        check("mis_resp_valid", resp_valid, 1);
        check("mis_resp_rdata", resp_rdata, 32'h55443322);
        check("mis_resp_err", resp_err, 0);
        tick();
`else
        issue(1'b0, 3'b010, 32'h01, 32'h0);
        check("mis_no_mem_req", mem_req, 0);
        check("mis_not_yet", resp_valid, 0);
        tick();
        check("mis_resp_valid", resp_valid, 1);
        check("mis_resp_err", resp_err, 1);
        check("mis_resp_rdata", resp_rdata, 0);
        check("mis_still_no_req", mem_req, 0);
        tick();
`endif

        // ---- illegal size code (D on a 32-bit bus)
        issue(1'b0, 3'b011, 32'h20, 32'h0);
        check("ill_no_mem_req", mem_req, 0);
        tick();
        check("ill_resp_valid", resp_valid, 1);
        check("ill_resp_err", resp_err, 1);
        tick();

        // ---- stray ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        check("stray_ack_resp", resp_valid, 0);
        check("stray_ack_ready", req_ready, 1);

        // ---- timeout: no ack for 4 wait cycles
        issue(1'b0, 3'b010, 32'h40, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_wait%0d_req", i), mem_req, 1);
            tick();
        end
        check("to_req_dropped", mem_req, 0);
        check("to_resp_valid", resp_valid, 1);
        check("to_resp_err", resp_err, 1);
        check("to_resp_rdata", resp_rdata, 0);
        tick();
        check("to_back_idle", req_ready, 1);

        // ---- reset in the middle of a later wait
        issue(1'b0, 3'b010, 32'h50, 32'h0);
        tick();
        check("rm_req_before", mem_req, 1);
        rst = 1'b1;
        tick();
        check("rm_req_dropped", mem_req, 0);
        check("rm_no_resp", resp_valid, 0);
        check("rm_ready_in_rst", req_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rm_quiet%0d", i), resp_valid, 0);
        end
        check("rm_ready_after", req_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
